pong_ball_engine: RTL and testbench

Parametrised ball engine for the VGA pong datapath: it replaces the fixed free-bouncing ball with a configurable one. It holds ball position, direction and speed, and advances them once per frame. It clamps and reflects at walls, bounces off left/right paddles with speed-up, detects misses, emits score pulses and runs a serve/miss state machine. It also generates the registered per-pixel ball mask for the colour mux.

---
 rtl/pong_ball_engine.sv | 229 ++++++++++++++++++++++
 tb/tb_pong_ball_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_engine.sv
`default_nettype none
// ============================================================================
//  Module   : pong_ball_engine
//  Brief    : Per-frame ball motion, wall/paddle bounces, miss scoring,
//             serve/miss state machine and registered per-pixel ball mask.
//  Revision : 1.0 - initial release
// ============================================================================
module pong_ball_engine #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BALL_SIZE   = 20,
    parameter int SPEED_X     = 11,
    parameter int SPEED_Y     = 11,
    parameter int MAX_SPEED   = 15,
    parameter int PADDLE_X    = 16,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int MISS_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [11:0] hcount,
    input  logic [10:0] vcount,
    input  logic [10:0] paddle_l_y,
    input  logic [10:0] paddle_r_y,
    input  logic        serve,
    output logic        draw_ball,
    output logic [11:0] ball_x,
    output logic [10:0] ball_y,
    output logic        score_l,
    output logic        score_r,
    output logic        playing
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_play = 2'd1;
    localparam logic [1:0] c_st_miss = 2'd2;

    localparam int c_cnt_w = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MISS_FRAMES - 1);

    localparam logic [11:0]        c_home_x      = 12'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0]        c_home_y      = 11'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic signed [12:0] c_ball        = 13'(BALL_SIZE);
    localparam logic signed [12:0] c_speed_y     = 13'(SPEED_Y);
    localparam logic signed [12:0] c_y_max       = 13'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [12:0] c_x_max       = 13'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [12:0] c_rf          = 13'(H_ACTIVE - PADDLE_X - PADDLE_W);
    localparam logic signed [12:0] c_lf          = 13'(PADDLE_X + PADDLE_W);
    localparam logic signed [12:0] c_paddle_h    = 13'(PADDLE_H);
    localparam logic [7:0]         c_serve_speed = 8'(SPEED_X);
    localparam logic [7:0]         c_max_speed   = 8'(MAX_SPEED);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [11:0]        r_ball_x;
    logic [10:0]        r_ball_y;
    logic               r_dx_right;
    logic               r_dy_down;
    logic               r_serve_right;
    logic [7:0]         r_speed_x;
    logic [c_cnt_w-1:0] r_miss_cnt;
    logic               r_score_l;
    logic               r_score_r;
    logic               r_draw;

    logic signed [12:0] w_x_ext;
    logic signed [12:0] w_y_ext;
    logic signed [12:0] w_spd;
    logic signed [12:0] w_nx;
    logic signed [12:0] w_ny;
    logic signed [12:0] w_pl_top;
    logic signed [12:0] w_pr_top;
    logic               w_ov_l;
    logic               w_ov_r;
    logic               w_hit_l;
    logic               w_hit_r;
    logic               w_miss_l;
    logic               w_miss_r;
    logic [10:0]        w_y_new;
    logic               w_dy_new;
    logic [7:0]         w_speed_up;
    logic               w_play_tick;
    logic               w_miss_done;
    logic               w_playing;
    logic               w_in_h;
    logic               w_in_v;

    // Candidate position, evaluated as signed so it can go negative or past the edge
    assign w_x_ext  = {1'b0, r_ball_x};
    assign w_y_ext  = {2'b00, r_ball_y};
    assign w_spd    = {5'b00000, r_speed_x};
    assign w_nx     = r_dx_right ? (w_x_ext + w_spd) : (w_x_ext - w_spd);
    assign w_ny     = r_dy_down ? (w_y_ext + c_speed_y) : (w_y_ext - c_speed_y);
    assign w_pl_top = {2'b00, paddle_l_y};
    assign w_pr_top = {2'b00, paddle_r_y};

    assign w_ov_l  = (w_ny + c_ball > w_pl_top) && (w_ny < w_pl_top + c_paddle_h);
    assign w_ov_r  = (w_ny + c_ball > w_pr_top) && (w_ny < w_pr_top + c_paddle_h);
    assign w_hit_r = r_dx_right && (w_nx + c_ball >= c_rf) && (w_x_ext + c_ball <= c_rf) && w_ov_r;
    assign w_hit_l = !r_dx_right && (w_nx <= c_lf) && (w_x_ext >= c_lf) && w_ov_l;

    assign w_miss_l = !(w_hit_l || w_hit_r) && (w_nx > c_x_max);
    assign w_miss_r = !(w_hit_l || w_hit_r) && (w_nx < 13'sd0);

    assign w_speed_up  = (r_speed_x >= c_max_speed) ? c_max_speed : (r_speed_x + 8'd1);
    assign w_play_tick = frame_tick && (r_state == c_st_play);
    assign w_miss_done = frame_tick && (r_state == c_st_miss) && (r_miss_cnt == c_cnt_last);

    always_comb begin
        w_y_new  = w_ny[10:0];
        w_dy_new = r_dy_down;
        if (w_ny >= c_y_max) begin
            w_y_new  = c_y_max[10:0];
            w_dy_new = 1'b0;
        end else if (w_ny <= 13'sd0) begin
            w_y_new  = 11'd0;
            w_dy_new = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (serve) w_next_state = c_st_play;
            c_st_play: if (w_play_tick && (w_miss_l || w_miss_r)) w_next_state = c_st_miss;
            c_st_miss: if (w_miss_done) w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        w_playing = (r_state == c_st_play);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ball_x      <= c_home_x;
            r_ball_y      <= c_home_y;
            r_dx_right    <= 1'b1;
            r_dy_down     <= 1'b1;
            r_serve_right <= 1'b1;
            r_speed_x     <= c_serve_speed;
            r_miss_cnt    <= '0;
            r_score_l     <= 1'b0;
            r_score_r     <= 1'b0;
        end else begin
            r_score_l <= 1'b0;
            r_score_r <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (serve) begin
                        r_speed_x  <= c_serve_speed;
                        r_dx_right <= r_serve_right;
                    end
                end
                c_st_play: begin
                    if (frame_tick) begin
                        if (w_miss_l || w_miss_r) begin
                            // Next serve heads toward whoever just conceded
                            r_score_l     <= w_miss_l;
                            r_score_r     <= w_miss_r;
                            r_serve_right <= w_miss_l;
                            r_miss_cnt    <= '0;
                        end else begin
                            r_ball_y  <= w_y_new;
                            r_dy_down <= w_dy_new;
                            if (w_hit_r) begin
                                r_ball_x   <= 12'(c_rf - c_ball);
                                r_dx_right <= 1'b0;
                                r_speed_x  <= w_speed_up;
                            end else if (w_hit_l) begin
                                r_ball_x   <= c_lf[11:0];
                                r_dx_right <= 1'b1;
                                r_speed_x  <= w_speed_up;
                            end else begin
                                r_ball_x <= w_nx[11:0];
                            end
                        end
                    end
                end
                c_st_miss: begin
                    if (w_miss_done) begin
                        r_miss_cnt <= '0;
                        r_ball_x   <= c_home_x;
                        r_ball_y   <= c_home_y;
                    end else if (frame_tick) begin
                        r_miss_cnt <= r_miss_cnt + 1'b1;
                    end
                end
                default: begin
                    r_miss_cnt <= '0;
                end
            endcase
        end
    end

    assign w_in_h = ({1'b0, hcount} >= {1'b0, r_ball_x}) &&
                    ({1'b0, hcount} <= ({1'b0, r_ball_x} + 13'(BALL_SIZE)));
    assign w_in_v = ({1'b0, vcount} >= {1'b0, r_ball_y}) &&
                    ({1'b0, vcount} <= ({1'b0, r_ball_y} + 12'(BALL_SIZE)));

    // Mask follows the state being entered so it is already dark on the first MISS cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_draw <= 1'b0;
        end else begin
            r_draw <= (w_next_state != c_st_miss) && w_in_h && w_in_v;
        end
    end

    assign draw_ball = r_draw;
    assign ball_x    = r_ball_x;
    assign ball_y    = r_ball_y;
    assign score_l   = r_score_l;
    assign score_r   = r_score_r;
    assign playing   = w_playing;

endmodule
`default_nettype wire

// File: tb/tb_pong_ball_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_ball_engine
//  Brief    : Scoreboard bench for pong_ball_engine motion, scoring and mask.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pong_ball_engine;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        frame_tick = 1'b0;
    logic [11:0] hcount     = 12'd0;
    logic [10:0] vcount     = 11'd0;
    logic [10:0] paddle_l_y = 11'd0;
    logic [10:0] paddle_r_y = 11'd0;
    logic        serve      = 1'b0;
    logic        draw_ball;
    logic [11:0] ball_x;
    logic [10:0] ball_y;
    logic        score_l;
    logic        score_r;
    logic        playing;

    typedef struct packed {
        logic [11:0] x;
        logic [10:0] y;
        logic        play;
        logic        sl;
        logic        sr;
    } exp_t;

    exp_t sb_q[$];
    logic draw_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    pong_ball_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .hcount     (hcount),
        .vcount     (vcount),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .serve      (serve),
        .draw_ball  (draw_ball),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score_l    (score_l),
        .score_r    (score_r),
        .playing    (playing)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(int x, int y, logic play, logic sl, logic sr);
        exp_t e;
        e.x    = 12'(x);
        e.y    = 11'(y);
        e.play = play;
        e.sl   = sl;
        e.sr   = sr;
        return e;
    endfunction

    // Expected position after the n-th PLAY tick of a serve from the centre, moving right/down
    function automatic exp_t pos(int n, bit hit_run);
        if (n <= 20) return mk(310 + 11 * n, 230 + 11 * n, 1'b1, 1'b0, 1'b0);
        case (n)
            21:      return mk(541, 460, 1'b1, 1'b0, 1'b0);
            22:      return mk(552, 449, 1'b1, 1'b0, 1'b0);
            23:      return mk(563, 438, 1'b1, 1'b0, 1'b0);
            24:      return mk(574, 427, 1'b1, 1'b0, 1'b0);
            25:      return mk(585, 416, 1'b1, 1'b0, 1'b0);
            26:      return mk(596, 405, 1'b1, 1'b0, 1'b0);
            27:      return mk(hit_run ? 584 : 607, 394, 1'b1, 1'b0, 1'b0);
            default: return mk(618, 383, 1'b1, 1'b0, 1'b0);
        endcase
    endfunction

    task automatic pulse_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic pulse_serve(input logic with_tick);
        @(negedge clk);
        serve      = 1'b1;
        frame_tick = with_tick;
        @(posedge clk);
        #1;
        serve      = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic d;
        rst_n = 1'b0;
        sb_q.push_back(mk(310, 230, 1'b0, 1'b0, 1'b0));
        draw_q.push_back(1'b0);
        repeat (3) @(posedge clk);
        #1;
        e = sb_q.pop_front();
        d = draw_q.pop_front();
        n_checks++;
        if ({ball_x, ball_y, playing, score_l, score_r} !== e || draw_ball !== d) begin
            n_errors++;
            $display("FAIL reset: x=%0d y=%0d play=%b sl=%b sr=%b draw=%b, want x=%0d y=%0d play=%b sl=%b sr=%b draw=%b",
                     ball_x, ball_y, playing, score_l, score_r, draw_ball, e.x, e.y, e.play, e.sl, e.sr, d);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_ticks();
        exp_t e;
        for (int i = 1; i <= 5; i++) begin
            sb_q.push_back(mk(310, 230, 1'b0, 1'b0, 1'b0));
            pulse_tick();
            e = sb_q.pop_front();
            n_checks++;
            if ({ball_x, ball_y, playing, score_l, score_r} !== e) begin
                n_errors++;
                $display("FAIL idle_tick%0d: x=%0d y=%0d play=%b sl=%b sr=%b, want x=%0d y=%0d play=%b",
                         i, ball_x, ball_y, playing, score_l, score_r, e.x, e.y, e.play);
            end
        end
    endtask

    task automatic test_serve_walls();
        exp_t e;
        paddle_r_y = 11'd380;
        sb_q.push_back(mk(310, 230, 1'b1, 1'b0, 1'b0));
        pulse_serve(1'b0);
        e = sb_q.pop_front();
        n_checks++;
        if ({ball_x, ball_y, playing, score_l, score_r} !== e) begin
            n_errors++;
            $display("FAIL serve: x=%0d y=%0d play=%b, want x=%0d y=%0d play=%b",
                     ball_x, ball_y, playing, e.x, e.y, e.play);
        end
        for (int n = 1; n <= 22; n++) begin
            sb_q.push_back(pos(n, 1'b1));
            pulse_tick();
            e = sb_q.pop_front();
            n_checks++;
            if ({ball_x, ball_y, playing, score_l, score_r} !== e) begin
                n_errors++;
                $display("FAIL wall_tick%0d: x=%0d y=%0d play=%b sl=%b sr=%b, want x=%0d y=%0d play=%b",
                         n, ball_x, ball_y, playing, score_l, score_r, e.x, e.y, e.play);
            end
        end
    endtask

    task automatic test_paddle_hit();
        exp_t e;
        for (int n = 23; n <= 27; n++) begin
            sb_q.push_back(pos(n, 1'b1));
            pulse_tick();
            e = sb_q.pop_front();
            n_checks++;
            if ({ball_x, ball_y, playing, score_l, score_r} !== e) begin
                n_errors++;
                $display("FAIL paddle_tick%0d: x=%0d y=%0d play=%b sl=%b sr=%b, want x=%0d y=%0d play=%b",
                         n, ball_x, ball_y, playing, score_l, score_r, e.x, e.y, e.play);
            end
        end
    endtask

    task automatic test_miss();
        exp_t e;
        logic d;
        async_reset();
        paddle_r_y = 11'd0;
        sb_q.push_back(mk(310, 230, 1'b1, 1'b0, 1'b0));
        pulse_serve(1'b1);
        e = sb_q.pop_front();
        n_checks++;
        if ({ball_x, ball_y, playing, score_l, score_r} !== e) begin
            n_errors++;
            $display("FAIL serve_with_tick: x=%0d y=%0d play=%b, want x=%0d y=%0d play=%b",
                     ball_x, ball_y, playing, e.x, e.y, e.play);
        end
        hcount = 12'd620;
        vcount = 11'd390;
        for (int n = 1; n <= 29; n++) begin
            sb_q.push_back(n == 29 ? mk(618, 383, 1'b0, 1'b1, 1'b0) : pos(n, 1'b0));
            pulse_tick();
            e = sb_q.pop_front();
            n_checks++;
            if ({ball_x, ball_y, playing, score_l, score_r} !== e) begin
                n_errors++;
                $display("FAIL miss_tick%0d: x=%0d y=%0d play=%b sl=%b sr=%b, want x=%0d y=%0d play=%b sl=%b sr=%b",
                         n, ball_x, ball_y, playing, score_l, score_r, e.x, e.y, e.play, e.sl, e.sr);
            end
        end
        sb_q.push_back(mk(618, 383, 1'b0, 1'b0, 1'b0));
        draw_q.push_back(1'b0);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        d = draw_q.pop_front();
        n_checks++;
        if ({ball_x, ball_y, playing, score_l, score_r} !== e || draw_ball !== d) begin
            n_errors++;
            $display("FAIL score_pulse_end: x=%0d y=%0d sl=%b sr=%b draw=%b, want x=%0d y=%0d sl=0 sr=0 draw=%b",
                     ball_x, ball_y, score_l, score_r, draw_ball, e.x, e.y, d);
        end
    endtask

    task automatic test_miss_hold();
        exp_t e;
        sb_q.push_back(mk(618, 383, 1'b0, 1'b0, 1'b0));
        pulse_serve(1'b0);
        e = sb_q.pop_front();
        n_checks++;
        if ({ball_x, ball_y, playing, score_l, score_r} !== e) begin
            n_errors++;
            $display("FAIL serve_in_miss: x=%0d y=%0d play=%b, want x=%0d y=%0d play=%b",
                     ball_x, ball_y, playing, e.x, e.y, e.play);
        end
        for (int n = 1; n <= 60; n++) begin
            sb_q.push_back(n < 60 ? mk(618, 383, 1'b0, 1'b0, 1'b0) : mk(310, 230, 1'b0, 1'b0, 1'b0));
            pulse_tick();
            e = sb_q.pop_front();
            n_checks++;
            if ({ball_x, ball_y, playing, score_l, score_r} !== e || (n < 60 && draw_ball !== 1'b0)) begin
                n_errors++;
                $display("FAIL miss_hold%0d: x=%0d y=%0d play=%b sl=%b sr=%b draw=%b, want x=%0d y=%0d play=%b draw=0",
                         n, ball_x, ball_y, playing, score_l, score_r, draw_ball, e.x, e.y, e.play);
            end
        end
    endtask

    task automatic test_reserve();
        exp_t e;
        sb_q.push_back(mk(310, 230, 1'b1, 1'b0, 1'b0));
        sb_q.push_back(mk(321, 219, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 2; k++) begin
            if (k == 0) pulse_serve(1'b0);
            else        pulse_tick();
            e = sb_q.pop_front();
            n_checks++;
            if ({ball_x, ball_y, playing, score_l, score_r} !== e) begin
                n_errors++;
                $display("FAIL reserve%0d: x=%0d y=%0d play=%b, want x=%0d y=%0d play=%b",
                         k, ball_x, ball_y, playing, e.x, e.y, e.play);
            end
        end
    endtask

    task automatic test_draw();
        int   tab_h [6] = '{310, 330, 331, 309, 320, 320};
        int   tab_v [6] = '{230, 250, 230, 230, 251, 229};
        logic tab_d [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic prev;
        logic d;
        async_reset();
        @(posedge clk);
        #1;
        prev = draw_ball;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hcount = 12'(tab_h[i]);
            vcount = 11'(tab_v[i]);
            draw_q.push_back(tab_d[i]);
            #1;
            if (i > 0) begin
                n_checks++;
                if (draw_ball !== prev) begin
                    n_errors++;
                    $display("FAIL draw_latency%0d: draw=%b, want %b", i, draw_ball, prev);
                end
            end
            @(posedge clk);
            #1;
            d = draw_q.pop_front();
            n_checks++;
            if (draw_ball !== d) begin
                n_errors++;
                $display("FAIL draw%0d h=%0d v=%0d: draw=%b, want %b", i, tab_h[i], tab_v[i], draw_ball, d);
            end
            prev = d;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic d;
        sb_q.push_back(mk(321, 241, 1'b1, 1'b0, 1'b0));
        pulse_serve(1'b0);
        pulse_tick();
        e = sb_q.pop_front();
        n_checks++;
        if ({ball_x, ball_y, playing, score_l, score_r} !== e) begin
            n_errors++;
            $display("FAIL pre_reset: x=%0d y=%0d play=%b, want x=%0d y=%0d play=%b",
                     ball_x, ball_y, playing, e.x, e.y, e.play);
        end
        @(negedge clk);
        hcount = 12'd321;
        vcount = 11'd241;
        draw_q.push_back(1'b1);
        @(posedge clk);
        #1;
        d = draw_q.pop_front();
        n_checks++;
        if (draw_ball !== d) begin
            n_errors++;
            $display("FAIL draw_in_play: draw=%b, want %b", draw_ball, d);
        end
        #2;
        sb_q.push_back(mk(310, 230, 1'b0, 1'b0, 1'b0));
        draw_q.push_back(1'b0);
        rst_n = 1'b0;
        #1;
        e = sb_q.pop_front();
        d = draw_q.pop_front();
        n_checks++;
        if ({ball_x, ball_y, playing, score_l, score_r} !== e || draw_ball !== d) begin
            n_errors++;
            $display("FAIL async_reset: x=%0d y=%0d play=%b sl=%b sr=%b draw=%b, want x=%0d y=%0d play=0 draw=%b",
                     ball_x, ball_y, playing, score_l, score_r, draw_ball, e.x, e.y, d);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle_ticks();
        test_serve_walls();
        test_paddle_hit();
        test_miss();
        test_miss_hold();
        test_reserve();
        test_draw();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
